// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Holds the 4-bit ALU control codes (also used by the ALU control decoder),
// the iterative ALU state encoding and the serial shifter mode encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic {
    IDLE,
    SHIFT
  } alu_state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_mode_t;

  // True for the three serial shift operations.
  function automatic logic is_shift_code(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter used for SLL/SRL/SRA.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears the counter)
//   load        - capture load_value/amount/mode; counter must be non-zero
//   load_value  - initial working value (A1)
//   amount      - number of single-bit shifts to perform
//   mode        - shift_mode_t encoding (logical left/right, arithmetic right)
//   value       - working register shifted by one more bit, i.e. the value
//                 the working register takes at the next stepping edge
//   last        - high when the counter is 1 (next edge is the final step)
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [SHW-1:0]   amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] value,
  output logic             last
);

  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  shift_mode_t      mode_q;

  always_comb begin
    value = work;
    case (mode_q)
      SH_LL:   value = {work[WIDTH-2:0], 1'b0};
      SH_RL:   value = {1'b0, work[WIDTH-1:1]};
      SH_RA:   value = {work[WIDTH-1], work[WIDTH-1:1]};
      default: value = work;
    endcase
  end

  assign last = (count == SHW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      work   <= '0;
      count  <= '0;
      mode_q <= SH_LL;
    end else if (load) begin
      work   <= load_value;
      count  <= amount;
      mode_q <= shift_mode_t'(mode);
    end else if (count != '0) begin
      work  <= value;
      count <= count - SHW'(1);
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU with Start/Ready handshake.
// Logic/arithmetic ops (and illegal codes, and shift-by-0) complete in one
// cycle; shifts by n>0 run serially through alu_serial_shifter.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   Start      - request, accepted only while Ready=1
//   Control    - 4-bit ALU control code, sampled on acceptance
//   A1, A2     - operands (A2[SHW-1:0] is the shift amount for shifts)
//   Ready      - high in IDLE (decoded from state)
//   Done       - one-cycle pulse when Result/Zero/Error are newly updated
//   Result     - registered result, held until the next Done
//   Zero       - registered (Result == 0)
//   Error      - set with Done for an undefined Control code
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       Control,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Error
);

  alu_state_t       state;
  logic [WIDTH-1:0] alu_y;
  logic             illegal;
  logic             is_shift;
  shift_mode_t      mode;
  logic [SHW-1:0]   amt;
  logic             start_shift;
  logic             shift_load;
  logic [WIDTH-1:0] shift_value;
  logic             shift_last;

  assign amt = A2[SHW-1:0];

  // One-cycle datapath. For shifts alu_y is A1, which is the correct
  // result when the amount is 0; non-zero amounts go to the serial shifter.
  always_comb begin
    alu_y   = '0;
    illegal = 1'b0;
    mode    = SH_LL;
    case (Control)
      ALU_AND:  alu_y = A1 & A2;
      ALU_OR:   alu_y = A1 | A2;
      ALU_ADD:  alu_y = A1 + A2;
      ALU_SUB:  alu_y = A1 - A2;
      ALU_XOR:  alu_y = A1 ^ A2;
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(A1) < $signed(A2))};
      ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (A1 < A2)};
      ALU_SLL: begin
        alu_y = A1;
        mode  = SH_LL;
      end
      ALU_SRL: begin
        alu_y = A1;
        mode  = SH_RL;
      end
      ALU_SRA: begin
        alu_y = A1;
        mode  = SH_RA;
      end
      default:  illegal = 1'b1;
    endcase
  end

  assign is_shift    = is_shift_code(Control);
  assign start_shift = is_shift && (amt != '0);
  assign Ready       = (state == IDLE);
  assign shift_load  = !reset && Ready && Start && start_shift;

  alu_serial_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (shift_load),
    .load_value (A1),
    .amount     (amt),
    .mode       (mode),
    .value      (shift_value),
    .last       (shift_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      Result <= '0;
      Zero   <= 1'b1;
      Error  <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (start_shift) begin
              state <= SHIFT;
            end else begin
              Result <= alu_y;
              Zero   <= (alu_y == '0);
              Error  <= illegal;
              Done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // shift_value is the working register after this edge's step,
          // so on the final step it is the finished result.
          if (shift_last) begin
            Result <= shift_value;
            Zero   <= (shift_value == '0);
            Error  <= 1'b0;
            Done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
module tb_iterative_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [3:0]   Control;
  logic [W-1:0] A1, A2;
  logic         Ready, Done, Zero, Error;
  logic [W-1:0] Result;

  always #5 clk = ~clk;

  iterative_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .Control (Control),
    .A1      (A1),
    .A2      (A2),
    .Ready   (Ready),
    .Done    (Done),
    .Result  (Result),
    .Zero    (Zero),
    .Error   (Error)
  );

  typedef struct {
    logic [W-1:0] result;
    logic         error;
    int unsigned  done_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned fails  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference: plain operators, shifts done in one step.
  task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic err, output int unsigned extra);
    int unsigned n;
    n     = b % W;
    err   = 1'b0;
    extra = 0;
    res   = '0;
    case (c)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0110: res = a - b;
      4'b0111: res = a ^ b;
      4'b0100: res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0101: res = (a < b) ? 1 : 0;
      4'b0011: begin res = a << n; extra = n; end
      4'b1000: begin res = a >> n; extra = n; end
      4'b1010: begin res = W'($signed(a) >>> n); extra = n; end
      default: begin res = '0; err = 1'b1; end
    endcase
  endtask

  // Presents a request at a negedge and holds Start until it is accepted.
  // Start stays high on return so consecutive calls are back-to-back.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    int unsigned extra;
    int unsigned n = 0;
    @(negedge clk);
    Start = 1'b1; Control = c; A1 = a; A2 = b;
    while (!Ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!Ready) begin
      checks++; fails++;
      $display("FAIL ready_timeout: Ready=0 required=1");
      Start = 1'b0;
      return;
    end
    model(c, a, b, e.result, e.error, extra);
    e.done_cyc = cyc + 1 + extra;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && Done) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_done: Done=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", Result, mon_e.result);
        check("zero", W'(Zero), W'(mon_e.result == '0));
        check("error", W'(Error), W'(mon_e.error));
        check("done_cycle", W'(cyc), W'(mon_e.done_cyc));
      end
    end
  end

  initial begin
    logic [3:0]  rc;
    int unsigned n;
    reset = 1'b1; Start = 1'b1; Control = ALU_ADD; A1 = 32'd1; A2 = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", W'(Ready), 1);
    check("reset_done", W'(Done), 0);
    check("reset_result", Result, 0);
    check("reset_zero", W'(Zero), 1);
    check("reset_error", W'(Error), 0);
    Start = 1'b0;
    reset = 1'b0;

    // Directed cases.
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1); idle();
    issue(ALU_SUB, 32'd5, 32'd7); idle();
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1); idle();
    issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1); idle();
    issue(ALU_SRA, 32'h8000_0000, 32'h0000_0024);
    // Busy: Start pulses with a different op must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_ready", W'(Ready), 0);
      Start = (i % 2 == 0); Control = ALU_ADD; A1 = 32'd3; A2 = 32'd4;
    end
    idle();
    issue(ALU_SLL, 32'd1, 32'd31); idle();
    issue(ALU_SRL, 32'hDEAD_BEEF, 32'h0000_0020); idle();
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0); idle();

    // Randomized mix with occasional idle gaps.
    for (int i = 0; i < 200; i++) begin
      rc = 4'($urandom_range(0, 15));
      issue(rc, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end

    // Reset in the middle of a long SRL.
    issue(ALU_SRL, $urandom, 32'd20);
    Start = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_ready", W'(Ready), 1);
    check("midreset_done", W'(Done), 0);
    check("midreset_result", Result, 0);
    check("midreset_zero", W'(Zero), 1);
    check("midreset_error", W'(Error), 0);
    sb.delete();
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // Back-to-back ADD stream with Start held high.
    for (int i = 0; i < 10; i++) issue(ALU_ADD, $urandom, $urandom);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
